regfile_dump_reader: RTL

- Read-side companion to the 32-bit enable-gated register storage used for the processor register file.
- On a start pulse, walks the register file read port from FIRST_REG to NUM_REGS-1 and streams each word out over a valid/ready handshake.
- Used by the checker/debug path to dump architectural state without touching the write port.
- Register file read is combinational (address in, data out in the same cycle).

---
 rtl/regfile_dump_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Purpose:
//   Read-side companion to the processor register file. A start pulse makes the
//   block walk the combinational read port from FIRST_REG up to NUM_REGS-1 and
//   stream every word out over a valid/ready handshake. The checker/debug path
//   uses it to dump architectural state without touching the write port.
//
// Optional feature (compile-time macro):
//   REGFILE_DUMP_SKIP_ZERO_EN - registers that read as zero are not presented.
//                               Each skipped register costs one cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   clear      in   synchronous active-high reset, highest priority
//   start      in   one-cycle dump request, honoured only in IDLE
//   rd_addr    out  register file read address
//   rd_data    in   register file read data (combinational from rd_addr)
//   out_valid  out  out_data/out_addr hold a word
//   out_ready  in   consumer takes the word when out_valid && out_ready
//   out_data   out  dumped register value
//   out_addr   out  address of out_data
//   busy       out  high from the cycle after start is accepted until DONE left
//   done       out  one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int FIRST_REG  = 0
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_e;

  // Full-width constants so the end-of-walk compare never relies on wrap.
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic                    out_valid_q, out_valid_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= S_IDLE;
      idx_q       <= FIRST_IDX;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    rd_addr     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        rd_addr = idx_q;
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
        if (rd_data == '0) begin
          // Zero word: advance straight from FETCH without presenting it.
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          out_data_d  = rd_data;
          out_addr_d  = idx_q;
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
`else
        out_data_d  = rd_data;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
`endif
      end

      S_SEND: begin
        // The word was captured in FETCH; rd_data is ignored here.
        rd_addr = idx_q;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
